// File: rtl/dmem_arbiter.sv
// Shared data-memory arbiter: the CPU and the graphics processor (GP) take turns on one memory port.
// The GP may keep the port for up to GP_BURST beats while the CPU is waiting.
module dmem_arbiter #(
   parameter int unsigned GP_BURST = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [3:0]  cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_din,
   output logic        cpu_stall,
   output logic [31:0] cpu_rdata,
   output logic        cpu_rvalid,
   input  logic        gp_req,
   input  logic [31:0] gp_addr,
   output logic        gp_ack,
   output logic [31:0] gp_rdata,
   output logic        gp_rvalid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic [3:0]  mem_we,
   output logic        mem_re,
   input  logic        mem_ready,
   input  logic [31:0] mem_dout
);

   typedef enum logic [1:0] {StIdle, StCpu, StGp} ownerE;

   localparam logic [8:0] burstLim = 9'(GP_BURST);
   localparam logic [7:0] burstSat = 8'(GP_BURST);

   ownerE      ownerQ, ownerD;
   logic [7:0] beatCntQ, beatCntD;
   logic [8:0] beatNext;
   logic       cpuRvQ, gpRvQ;
   logic       cpuAcc, gpAcc;

   assign cpuAcc = (ownerQ == StCpu) & cpu_req & mem_ready;
   assign gpAcc  = (ownerQ == StGp) & gp_req & mem_ready;

   assign cpu_stall = cpu_req & ~((ownerQ == StCpu) & mem_ready);
   assign gp_ack    = gpAcc;

   // Gating with rst also drops a pulse whose read completed just before reset arrived.
   assign cpu_rvalid = cpuRvQ & ~rst;
   assign gp_rvalid  = gpRvQ & ~rst;
   assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
   assign gp_rdata   = gp_rvalid ? mem_dout : '0;

   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_we   = '0;
      mem_re   = 1'b0;
      unique case (ownerQ)
         StCpu: begin
            mem_addr = cpu_addr;
            mem_din  = cpu_din;
            mem_we   = cpu_we;
            mem_re   = (cpu_we == 4'b0000) & cpu_req;
         end
         StGp: begin
            mem_addr = gp_addr;
            mem_re   = gp_req;
         end
         default: ;
      endcase
   end

   always_comb begin
      ownerD   = ownerQ;
      beatCntD = beatCntQ;
      beatNext = {1'b0, beatCntQ} + 9'd1;
      unique case (ownerQ)
         StIdle: begin
            if (cpu_req)     ownerD = StCpu;
            else if (gp_req) ownerD = StGp;
         end
         StCpu: begin
            if (cpuAcc)        ownerD = gp_req ? StGp : StCpu;
            else if (!cpu_req) ownerD = gp_req ? StGp : StIdle;
         end
         StGp: begin
            if (gpAcc) begin
               if (cpu_req && beatNext >= burstLim) ownerD = StCpu;
               else                                 ownerD = StGp;
               // Hold at the limit while the CPU is idle so a long burst cannot wrap.
               beatCntD = (beatNext >= burstLim) ? burstSat : beatNext[7:0];
            end else if (!gp_req) begin
               ownerD = cpu_req ? StCpu : StIdle;
            end
         end
         default: ownerD = StIdle;
      endcase
      if (ownerD != StGp) beatCntD = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ownerQ   <= StIdle;
         beatCntQ <= '0;
         cpuRvQ   <= 1'b0;
         gpRvQ    <= 1'b0;
      end else begin
         ownerQ   <= ownerD;
         beatCntQ <= beatCntD;
         cpuRvQ   <= cpuAcc & (cpu_we == 4'b0000);
         gpRvQ    <= gpAcc;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios, an ownership model checked every cycle,
// and literal expectations at the key points of each scenario.
module tb_dmem_arbiter;

   localparam int Burst   = 4;
   localparam int OwnNone = 0;
   localparam int OwnCpu  = 1;
   localparam int OwnGp   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [3:0]  cpu_we;
   logic [31:0] cpu_addr, cpu_din;
   logic        cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        gp_req, gp_ack, gp_rvalid;
   logic [31:0] gp_addr, gp_rdata;
   logic [31:0] mem_addr, mem_din, mem_dout;
   logic [3:0]  mem_we;
   logic        mem_re, mem_ready;

   logic        autoDout;
   logic [31:0] fixedDout, rndDout;

   int nChecks = 0;
   int nErrors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) rndDout <= $urandom;
   assign mem_dout = autoDout ? rndDout : fixedDout;

   dmem_arbiter #(.GP_BURST(Burst)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .gp_req(gp_req), .gp_addr(gp_addr), .gp_ack(gp_ack),
      .gp_rdata(gp_rdata), .gp_rvalid(gp_rvalid),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
      .mem_ready(mem_ready), .mem_dout(mem_dout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: who owns the port, how many GP beats this tenure, which reads return next cycle.
   bit mValid = 0;
   int mOwner = OwnNone;
   int mBeats = 0;
   bit mCpuRv = 0;
   bit mGpRv  = 0;
   bit cAcc, gAcc;
   int nxt;

   always @(posedge clk) begin
      if (rst) begin
         mValid = 1;
         mOwner = OwnNone;
         mBeats = 0;
         mCpuRv = 0;
         mGpRv  = 0;
      end else begin
         cAcc   = (mOwner == OwnCpu) && cpu_req && mem_ready;
         gAcc   = (mOwner == OwnGp) && gp_req && mem_ready;
         mCpuRv = cAcc && (cpu_we == 4'b0000);
         mGpRv  = gAcc;
         nxt    = mOwner;
         if (mOwner == OwnNone) nxt = cpu_req ? OwnCpu : (gp_req ? OwnGp : OwnNone);
         else if (cAcc) nxt = gp_req ? OwnGp : OwnCpu;
         else if (gAcc) begin
            mBeats = mBeats + 1;
            nxt = (cpu_req && mBeats >= Burst) ? OwnCpu : OwnGp;
         end
         else if (mOwner == OwnCpu && !cpu_req) nxt = gp_req ? OwnGp : OwnNone;
         else if (mOwner == OwnGp && !gp_req) nxt = cpu_req ? OwnCpu : OwnNone;
         if (nxt != OwnGp) mBeats = 0;
         mOwner = nxt;
      end
   end

   always @(negedge clk) begin
      if (mValid) begin
         logic [31:0] eAddr, eDin;
         logic [3:0]  eWe;
         logic        eRe, eStall, eAck, eCrv, eGrv;
         eAddr = 32'h0; eDin = 32'h0; eWe = 4'h0; eRe = 1'b0;
         if (mOwner == OwnCpu) begin
            eAddr = cpu_addr; eDin = cpu_din; eWe = cpu_we;
            eRe = (cpu_we == 4'h0) && cpu_req;
         end else if (mOwner == OwnGp) begin
            eAddr = gp_addr; eRe = gp_req;
         end
         eStall = cpu_req && !(mOwner == OwnCpu && mem_ready);
         eAck   = (mOwner == OwnGp) && gp_req && mem_ready;
         eCrv   = mCpuRv && !rst;
         eGrv   = mGpRv && !rst;
         chk("cpu_stall", 32'(cpu_stall), 32'(eStall));
         chk("mem_re", 32'(mem_re), 32'(eRe));
         chk("mem_we", 32'(mem_we), 32'(eWe));
         chk("gp_ack", 32'(gp_ack), 32'(eAck));
         chk("cpu_rvalid", 32'(cpu_rvalid), 32'(eCrv));
         chk("gp_rvalid", 32'(gp_rvalid), 32'(eGrv));
         chk("cpu_rdata", cpu_rdata, eCrv ? mem_dout : 32'h0);
         chk("gp_rdata", gp_rdata, eGrv ? mem_dout : 32'h0);
         if (mOwner != OwnNone) begin
            chk("mem_addr", mem_addr, eAddr);
            chk("mem_din", mem_din, eDin);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   int    ackCnt;
   string seq;

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = 32'h0; cpu_din = 32'h0;
      gp_req = 1'b0; gp_addr = 32'h0; mem_ready = 1'b1;
      autoDout = 1'b1; fixedDout = 32'h0;
      tick(); tick();
      mid();
      chk("rst mem_re", 32'(mem_re), 32'h0);
      chk("rst gp_ack", 32'(gp_ack), 32'h0);
      chk("rst cpu_rdata", cpu_rdata, 32'h0);
      tick();
      cpu_req = 1'b1; cpu_addr = 32'h1000;
      mid();
      chk("rst stall follows req", 32'(cpu_stall), 32'h1);

      // CPU read alone
      tick();
      rst = 1'b0; autoDout = 1'b0; fixedDout = 32'hDEADBEEF;
      mid();
      chk("rd idle stall", 32'(cpu_stall), 32'h1);
      chk("rd idle mem_re", 32'(mem_re), 32'h0);
      tick(); mid();
      chk("rd mem_re", 32'(mem_re), 32'h1);
      chk("rd mem_addr", mem_addr, 32'h1000);
      chk("rd stall drop", 32'(cpu_stall), 32'h0);
      tick();
      cpu_req = 1'b0;
      mid();
      chk("rd rvalid", 32'(cpu_rvalid), 32'h1);
      chk("rd rdata", cpu_rdata, 32'hDEADBEEF);
      tick();

      // CPU write
      cpu_req = 1'b1; cpu_we = 4'b0011; cpu_addr = 32'h2004; cpu_din = 32'h12345678;
      autoDout = 1'b1;
      mid();
      chk("wr idle stall", 32'(cpu_stall), 32'h1);
      tick(); mid();
      chk("wr mem_we", 32'(mem_we), 32'h3);
      chk("wr mem_din", mem_din, 32'h12345678);
      chk("wr stall drop", 32'(cpu_stall), 32'h0);
      tick();
      cpu_req = 1'b0; cpu_we = 4'h0;
      mid();
      chk("wr no rvalid", 32'(cpu_rvalid), 32'h0);
      tick();

      // GP burst limited while CPU waits
      gp_req = 1'b1; gp_addr = 32'h8000; cpu_addr = 32'h3000;
      ackCnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) cpu_req = 1'b1;
         mid();
         if (gp_ack) ackCnt++;
      end
      chk("burst ack count", 32'(ackCnt), 32'd4);
      chk("burst cpu addr", mem_addr, 32'h3000);
      chk("burst cpu granted", 32'(cpu_stall), 32'h0);
      tick();
      cpu_req = 1'b0; gp_req = 1'b0;
      tick(); tick();

      // Both requesting continuously
      cpu_req = 1'b1; gp_req = 1'b1; cpu_addr = 32'h5000; gp_addr = 32'h6000;
      mid();
      chk("both idle stall", 32'(cpu_stall), 32'h1);
      seq = "";
      for (int i = 0; i < 11; i++) begin
         tick(); mid();
         if (cpu_req && !cpu_stall) seq = {seq, "C"};
         else if (gp_ack)           seq = {seq, "G"};
         else                       seq = {seq, "-"};
      end
      nChecks++;
      if (seq != "CGGGGCGGGGC") begin
         nErrors++;
         $display("FAIL both grant order: got %s expected CGGGGCGGGGC", seq);
      end
      tick();
      cpu_req = 1'b0; gp_req = 1'b0;
      tick(); tick();

      // mem_ready low for three cycles during a GP read
      gp_req = 1'b1; gp_addr = 32'h4440; mem_ready = 1'b0;
      autoDout = 1'b0; fixedDout = 32'hCAFE0042;
      tick();
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("wait no ack", 32'(gp_ack), 32'h0);
         chk("wait addr", mem_addr, 32'h4440);
         chk("wait mem_re", 32'(mem_re), 32'h1);
         tick();
      end
      mem_ready = 1'b1;
      mid();
      chk("wait ack", 32'(gp_ack), 32'h1);
      tick();
      gp_req = 1'b0;
      mid();
      chk("wait gp_rvalid", 32'(gp_rvalid), 32'h1);
      chk("wait gp_rdata", gp_rdata, 32'hCAFE0042);
      tick();

      // Reset right after an accepted CPU read
      cpu_req = 1'b1; cpu_addr = 32'h7000; fixedDout = 32'h0BADF00D;
      tick(); tick();
      rst = 1'b1; cpu_req = 1'b0;
      mid();
      chk("rst rvalid suppressed", 32'(cpu_rvalid), 32'h0);
      chk("rst rdata zero", cpu_rdata, 32'h0);
      tick();
      rst = 1'b0; cpu_req = 1'b1;
      mid();
      chk("post rst idle stall", 32'(cpu_stall), 32'h1);
      chk("post rst mem_re", 32'(mem_re), 32'h0);
      tick();
      cpu_req = 1'b0;
      tick(); tick();

      // GP drops its request before acceptance; waiting CPU takes over
      gp_req = 1'b1; gp_addr = 32'h9000; mem_ready = 1'b0; cpu_addr = 32'hA000;
      tick();
      cpu_req = 1'b1;
      tick();
      gp_req = 1'b0;
      mid();
      chk("drop gp mem_re", 32'(mem_re), 32'h0);
      tick();
      mem_ready = 1'b1;
      mid();
      chk("drop cpu addr", mem_addr, 32'hA000);
      chk("drop cpu stall", 32'(cpu_stall), 32'h0);
      tick();
      cpu_req = 1'b0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
